// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 8-bit combinational ALU.
// Requests are granted round-robin. Each accepted operation spends one cycle in
// execute and is then presented as a result until the consumer takes it.
module alu_arbiter (
    input  logic       CLK,
    input  logic       RSTN,

    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_A,
    input  logic [7:0] REQ0_B,
    input  logic [2:0] REQ0_SEL,
    output logic       REQ0_READY,

    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_A,
    input  logic [7:0] REQ1_B,
    input  logic [2:0] REQ1_SEL,
    output logic       REQ1_READY,

    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [2:0] ALU_SEL,
    input  logic [7:0] ALU_OUT,

    output logic       RES_VALID,
    output logic       RES_ID,
    output logic [7:0] RES_DATA,
    output logic       RES_ERR,
    input  logic       RES_READY
);

    localparam logic [2:0] OpDiv = 3'b011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

    state_t     state_q;

    // Operation in flight; the ALU only ever sees these registers.
    logic [7:0] op_a_q;
    logic [7:0] op_b_q;
    logic [2:0] op_sel_q;
    logic       owner_q;

    // Requester granted most recently; resets to 1 so requester 0 wins the first tie.
    logic       last_grant_q;

    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic       res_err_q;

    logic       any_valid;
    logic       both_valid;
    logic       grant;
    logic       grant_id;
    logic [7:0] grant_a;
    logic [7:0] grant_b;
    logic [2:0] grant_sel;
    logic       div_by_zero;

    // Round-robin grant decision; reset gates it so READY stays low while RSTN is low.
    always_comb begin
        any_valid  = REQ0_VALID | REQ1_VALID;
        both_valid = REQ0_VALID & REQ1_VALID;
        grant      = RSTN && (state_q == StIdle) && any_valid;
        if (both_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = REQ1_VALID;
        end
    end

    // Operand mux for the requester being granted.
    always_comb begin
        if (grant_id) begin
            grant_a   = REQ1_A;
            grant_b   = REQ1_B;
            grant_sel = REQ1_SEL;
        end else begin
            grant_a   = REQ0_A;
            grant_b   = REQ0_B;
            grant_sel = REQ0_SEL;
        end
    end

    // Divide-by-zero is judged on the registered operands, never on the live inputs.
    always_comb begin
        div_by_zero = (op_sel_q == OpDiv) && (op_b_q == 8'h00);
    end

    // Controller: grant in idle, capture the ALU result after one execute cycle,
    // then hold the result until the consumer accepts it.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= StIdle;
            op_a_q       <= 8'h00;
            op_b_q       <= 8'h00;
            op_sel_q     <= 3'b000;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_data_q   <= 8'h00;
            res_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        op_a_q       <= grant_a;
                        op_b_q       <= grant_b;
                        op_sel_q     <= grant_sel;
                        owner_q      <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    // A zero divisor yields all-ones regardless of what the ALU returns.
                    res_data_q  <= div_by_zero ? 8'hFF : ALU_OUT;
                    res_err_q   <= div_by_zero;
                    res_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (RES_READY) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign REQ0_READY = grant & ~grant_id;
    assign REQ1_READY = grant &  grant_id;

    assign ALU_A      = op_a_q;
    assign ALU_B      = op_b_q;
    assign ALU_SEL    = op_sel_q;

    assign RES_VALID  = res_valid_q;
    assign RES_ID     = owner_q;
    assign RES_DATA   = res_data_q;
    assign RES_ERR    = res_err_q;

    // Structural invariants of the handshake.
    a_ready_onehot: assert property (@(posedge CLK) disable iff (!RSTN)
        !(REQ0_READY && REQ1_READY));
    a_ready_idle_only: assert property (@(posedge CLK) disable iff (!RSTN)
        (REQ0_READY || REQ1_READY) |-> (state_q == StIdle));
    a_valid_resp_only: assert property (@(posedge CLK) disable iff (!RSTN)
        RES_VALID |-> (state_q == StResp));
    a_result_stable: assert property (@(posedge CLK) disable iff (!RSTN)
        (RES_VALID && !RES_READY) |=> (RES_VALID && $stable(RES_DATA) &&
                                       $stable(RES_ID) && $stable(RES_ERR)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised self-checking bench for alu_arbiter with a transaction-level reference
// model and a behavioural stand-in for the shared ALU.
module tb_alu_arbiter;

    logic       clk;
    logic       rstn;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic       req0_ready, req1_ready;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       res_valid, res_id, res_err, res_ready;
    logic [7:0] res_data;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: requester granted most recently (1 after reset).
    logic model_last;

    alu_arbiter dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .REQ0_VALID (req0_valid),
        .REQ0_A     (req0_a),
        .REQ0_B     (req0_b),
        .REQ0_SEL   (req0_sel),
        .REQ0_READY (req0_ready),
        .REQ1_VALID (req1_valid),
        .REQ1_A     (req1_a),
        .REQ1_B     (req1_b),
        .REQ1_SEL   (req1_sel),
        .REQ1_READY (req1_ready),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_SEL    (alu_sel),
        .ALU_OUT    (alu_out),
        .RES_VALID  (res_valid),
        .RES_ID     (res_id),
        .RES_DATA   (res_data),
        .RES_ERR    (res_err),
        .RES_READY  (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain-integer ALU semantics; a zero divisor gives 0xFF with the error flag.
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] sel,
                                   output logic [7:0] data, output logic err);
        int ai, bi, r;
        ai  = int'(a);
        bi  = int'(b);
        r   = 0;
        err = 1'b0;
        case (sel)
            3'd0: r = ai + bi;
            3'd1: r = ai - bi;
            3'd2: r = ai * bi;
            3'd3: if (bi == 0) begin r = 255; err = 1'b1; end else r = ai / bi;
            3'd4: r = ai & bi;
            3'd5: r = ai | bi;
            3'd6: r = ai ^ bi;
            default: r = ~(ai ^ bi);
        endcase
        data = 8'(r);
    endfunction

    // Shared ALU stand-in; returns a junk value on divide-by-zero so the override shows.
    always_comb begin
        logic [7:0] d;
        logic       e;
        ref_op(alu_a, alu_b, alu_sel, d, e);
        alu_out = e ? 8'h5A : d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_a"},     32'(alu_a),      32'h0);
        check({tag, ".alu_b"},     32'(alu_b),      32'h0);
        check({tag, ".alu_sel"},   32'(alu_sel),    32'h0);
        check({tag, ".res_valid"}, 32'(res_valid),  32'h0);
        check({tag, ".res_id"},    32'(res_id),     32'h0);
        check({tag, ".res_data"},  32'(res_data),   32'h0);
        check({tag, ".res_err"},   32'(res_err),    32'h0);
        check({tag, ".ready0"},    32'(req0_ready), 32'h0);
        check({tag, ".ready1"},    32'(req1_ready), 32'h0);
    endtask

    task automatic scramble_reqs();
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 3'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 3'($urandom);
    endtask

    // Hold reset for two cycles with requests pending; release mid-cycle.
    task automatic do_reset();
        rstn = 1'b0;
        res_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rstn = 1'b1;
        model_last = 1'b1;
    endtask

    // One transaction, entered #1 after a rising edge with the DUT idle and left the
    // same way. hold = cycles the result waits before the consumer accepts it.
    task automatic txn(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [2:0] s0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                       input logic [2:0] s1,
                       input int hold, input bit scramble);
        logic       w;
        logic [7:0] ea, eb, ed;
        logic [2:0] es;
        logic       ee;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
        res_ready  = 1'($urandom);
        if (!v0 && !v1) begin
            @(negedge clk);
            check("idle.ready0", 32'(req0_ready), 32'h0);
            check("idle.ready1", 32'(req1_ready), 32'h0);
            check("idle.res_valid", 32'(res_valid), 32'h0);
            @(posedge clk);
            #1;
            return;
        end
        w  = (v0 && v1) ? ~model_last : v1;
        model_last = w;
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        es = w ? s1 : s0;
        ref_op(ea, eb, es, ed, ee);

        @(negedge clk);
        check("grant.ready0", 32'(req0_ready), 32'(!w));
        check("grant.ready1", 32'(req1_ready), 32'(w));
        check("grant.res_valid", 32'(res_valid), 32'h0);
        @(posedge clk);
        #1;
        if (scramble) scramble_reqs();
        res_ready = 1'($urandom);
        @(negedge clk);
        check("exec.ready0", 32'(req0_ready), 32'h0);
        check("exec.ready1", 32'(req1_ready), 32'h0);
        check("exec.res_valid", 32'(res_valid), 32'h0);
        check("exec.alu_a", 32'(alu_a), 32'(ea));
        check("exec.alu_b", 32'(alu_b), 32'(eb));
        check("exec.alu_sel", 32'(alu_sel), 32'(es));
        @(posedge clk);
        #1;
        for (int k = 0; k <= hold; k++) begin
            res_ready = (k == hold);
            if (scramble) scramble_reqs();
            @(negedge clk);
            check("resp.res_valid", 32'(res_valid), 32'h1);
            check("resp.res_id", 32'(res_id), 32'(w));
            check("resp.res_data", 32'(res_data), 32'(ed));
            check("resp.res_err", 32'(res_err), 32'(ee));
            check("resp.ready0", 32'(req0_ready), 32'h0);
            check("resp.ready1", 32'(req1_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = 8'h0; req0_b = 8'h0; req0_sel = 3'h0;
        req1_valid = 1'b0; req1_a = 8'h0; req1_b = 8'h0; req1_sel = 3'h0;
        model_last = 1'b1;
        #2;

        // Single ADD from requester 0.
        do_reset();
        txn(1'b1, 8'h05, 8'h03, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 0, 1'b0);

        // Continuous tie: SUB from 0 and AND from 1 must alternate, starting with 0.
        do_reset();
        for (int i = 0; i < 4; i++)
            txn(1'b1, 8'h03, 8'h05, 3'd1, 1'b1, 8'hF0, 8'h3C, 3'd4, 0, 1'b0);

        // Divide by zero, then a legal divide, both from requester 1.
        txn(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h40, 8'h00, 3'd3, 0, 1'b0);
        txn(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h40, 8'h04, 3'd3, 0, 1'b0);

        // MUL overflowing to 0x00 with the consumer stalling four cycles.
        txn(1'b1, 8'h10, 8'h10, 3'd2, 1'b0, 8'h00, 8'h00, 3'd0, 4, 1'b0);

        // Reset pulsed during execute aborts the operation.
        do_reset();
        req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h0F; req0_sel = 3'd6;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        check("abort.grant0", 32'(req0_ready), 32'h1);
        @(posedge clk);
        #1;
        check("abort.exec_alu_a", 32'(alu_a), 32'hAA);
        req1_valid = 1'b1;
        rstn = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.no_result", 32'(res_valid), 32'h0);
            check("abort.no_ready0", 32'(req0_ready), 32'h0);
            check("abort.no_ready1", 32'(req1_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        txn(1'b1, 8'h12, 8'h34, 3'd5, 1'b1, 8'h56, 8'h78, 3'd7, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            logic       v0, v1;
            logic [7:0] b0, b1;
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 7);
            b0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            b1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            txn(v0, 8'($urandom), b0, 3'($urandom), v1, 8'($urandom), b1, 3'($urandom),
                int'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; all datapaths are 8 bits and opcodes 3 bits, matching the team's 8-bit ALU.
REQ-002 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 REQ0_VALID  input  1  requester 0 has an operation pending.
REQ-005 REQ0_A, REQ0_B  input  8 each  requester 0 operands.
REQ-006 REQ0_SEL  input  3  requester 0 opcode (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 XNOR).
REQ-007 REQ0_READY  output  1  requester 0 operation accepted this cycle.
REQ-008 REQ1_VALID, REQ1_A, REQ1_B, REQ1_SEL, REQ1_READY: same directions, widths and meanings for requester 1.
REQ-009 ALU_A, ALU_B  output  8 each  operands driven to the shared ALU.
REQ-010 ALU_SEL  output  3  opcode driven to the shared ALU.
REQ-011 ALU_OUT  input  8  combinational result returned by the shared ALU.
REQ-012 RES_VALID  output  1  result available.
REQ-013 RES_ID  output  1  requester that owns the result (0 or 1).
REQ-014 RES_DATA  output  8  result value.
REQ-015 RES_ERR  output  1  divide-by-zero flag for the result.
REQ-016 RES_READY  input  1  consumer accepts the result.

Function
REQ-017 The controller SHALL be a three-state FSM: IDLE, EXEC, RESP.
REQ-018 IDLE: if any REQn_VALID is high, grant one requester, register its A/B/SEL into the operand registers, set the owner to n, and go to EXEC; otherwise stay in IDLE.
REQ-019 REQn_READY SHALL be combinational, high only in IDLE in the cycle requester n is granted; at most one READY is high per cycle; both are low in EXEC and RESP.
REQ-020 Arbitration SHALL be round-robin: with both VALID high, grant the requester not granted last; with one VALID high, grant it regardless of history.
REQ-021 The last-grant pointer SHALL update only on a grant.
REQ-022 ALU_A/ALU_B/ALU_SEL SHALL always be driven from the operand registers, never directly from the request inputs.
REQ-023 EXEC: lasts exactly one cycle; at its end, capture ALU_OUT into RES_DATA and go to RESP.
REQ-024 Divide-by-zero: if the registered SEL is 011 and the registered B is 0, EXEC SHALL capture RES_DATA = 8'hFF and RES_ERR = 1, ignoring ALU_OUT; otherwise RES_ERR = 0.
REQ-025 Results SHALL be the low 8 bits of the ALU output; no carry or overflow is reported.
REQ-026 RESP: RES_VALID = 1; RES_DATA, RES_ID and RES_ERR held stable; go to IDLE on the cycle RES_READY = 1; otherwise hold indefinitely.
REQ-027 RES_VALID SHALL be 0 in IDLE and EXEC.
REQ-028 Latency: a grant in cycle N gives RES_VALID high in cycle N+2. Minimum issue interval is 3 cycles; the next grant is possible in the cycle after the result handshake.
REQ-029 Request inputs changing while in EXEC or RESP SHALL have no effect on the operation in flight.

Reset
REQ-030 While RSTN = 0, state is IDLE and the following are 0: operand registers, ALU_A, ALU_B, ALU_SEL, RES_VALID, RES_ID, RES_DATA, RES_ERR, REQ0_READY and REQ1_READY.
REQ-031 Reset SHALL set the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation; no result is delivered for it after reset is released.

Verification
REQ-033 After reset, REQ0: A=8'h05, B=8'h03, SEL=000, RES_READY=1 -> REQ0_READY high for 1 cycle; 2 cycles later RES_VALID=1, RES_ID=0, RES_DATA=8'h08, RES_ERR=0.
REQ-034 Both VALID high continuously: REQ0 SUB 8'h03-8'h05, REQ1 AND 8'hF0&8'h3C -> first result ID 0, data 8'hFE; second result ID 1, data 8'h30; grants strictly alternate afterwards.
REQ-035 REQ1 DIV with A=8'h40, B=8'h00 -> RES_DATA=8'hFF, RES_ERR=1. Then REQ1 DIV with A=8'h40, B=8'h04 -> RES_DATA=8'h10, RES_ERR=0.
REQ-036 REQ0 MUL 8'h10*8'h10 with RES_READY held low 4 cycles -> RES_VALID and RES_DATA=8'h00 held stable; no READY asserted until the cycle after RES_READY rises.
REQ-037 RSTN pulsed low during EXEC of REQ0 XOR 8'hAA^8'h0F -> all outputs 0 immediately; no RES_VALID follows; the next tie after release grants requester 0.
